draw_player: RTL and testbench
==============================

// Module: draw_player
// PURPOSE
//  Overlay stage directly downstream of the background renderer. Takes its VGA timing + rgb stream, draws a
//  mouse-steered player square clamped inside the game arena, tracks lives on obstacle hits with frame-based
//  invulnerability blinking, and pulses game_over back to the mode logic when lives run out.
// PARAMETERS
//  TOP_V_LINE      317      arena top edge (inner), pixels
//  BOTTOM_V_LINE   617      arena bottom edge (inner, exclusive)
//  LEFT_H_LINE     361      arena left edge (inner)
//  RIGHT_H_LINE    661      arena right edge (inner, exclusive)
//  SIZE            16       player square side, pixels
//  COLOR           12'hf_0_0 player colour
//  LIVES           3        lives at game start (1..7)
//  INVULN_FRAMES   60       frames of hit immunity after a hit (1..255)
// PORTS
//  pclk            in   1   pixel clock
//  rst             in   1   synchronous, active-high reset
//  vcount_in/hcount_in in 12 timing counters from background stage
//  vsync_in/hsync_in/vblnk_in/hblnk_in in 1 timing strobes
//  rgb_in          in   12  background pixel
//  mouse_mode      in   2   2'b01 = game mode; any other value = not playing
//  xpos/ypos       in   12  mouse position
//  hit             in   1   obstacle collision, sampled every cycle
//  vcount_out/hcount_out/vsync_out/hsync_out/vblnk_out/hblnk_out out  timing, delayed 2 cycles
//  rgb_out         out  12  composited pixel, aligned with timing outputs
//  player_x/player_y out 12 current top-left of player square
//  lives           out  3   remaining lives
//  game_over       out  1   one-cycle pulse on last life lost
// BEHAVIOUR
//  Reset: state IDLE; all timing outs, rgb_out, game_over = 0; lives = LIVES;
//   player_x = (LEFT_H_LINE+RIGHT_H_LINE-SIZE)/2 (503), player_y = (TOP_V_LINE+BOTTOM_V_LINE-SIZE)/2 (459).
//  Pipeline: 2 registered stages, fixed latency 2 for every timing/rgb output. Stage 1 registers inputs and
//   computes inside = hcount in [player_x, player_x+SIZE) and vcount in [player_y, player_y+SIZE), blanking off.
//   Stage 2: rgb_out = (inside && visible) ? COLOR : rgb_in (delayed); blanking -> rgb_in passed unchanged.
//  Frame tick: vblnk_in rising edge (registered previous value), one cycle per frame.
//  Position: on frame tick in PLAY/INVULN, player_x = clamp(xpos, LEFT_H_LINE, RIGHT_H_LINE-SIZE),
//   player_y = clamp(ypos, TOP_V_LINE, BOTTOM_V_LINE-SIZE); unsigned 12-bit compares. Held mid-frame.
//  FSM:
//   IDLE   : not drawn, position held at centre, lives=LIVES. mouse_mode==01 -> PLAY.
//   PLAY   : drawn. hit -> lives-1; if result 0 -> DEAD, else INVULN with inv_cnt=INVULN_FRAMES.
//   INVULN : hits ignored; inv_cnt-1 each frame tick; tick with inv_cnt==1 -> PLAY.
//            visible only when inv_cnt[2]==0 (blink every 4 frames).
//   DEAD   : not drawn, lives=0; game_over=1 only in the PLAY->DEAD cycle.
//  Any state with mouse_mode!=01 -> IDLE next cycle, lives reloaded, position recentred; overrides hit.
//  Hit held high several cycles counts once (PLAY leaves on first cycle). hit + frame tick same cycle: both apply.
//  In IDLE/DEAD, visible=0 so rgb_out equals rgb_in delayed 2 cycles.
// TESTING
//  1 rst, mouse_mode=01, xpos=100, ypos=900, one vblnk rise -> player_x=361, player_y=601.
//  2 player at (503,459), hcount=503,vcount=459,rgb_in=0 -> rgb_out=F00 2 cycles later; hcount=519 -> rgb_out=rgb_in.
//  3 PLAY, hit 1 cycle -> lives 3->2, INVULN; hit again 10 frames later -> lives stays 2; after 60 ticks -> PLAY.
//  4 Three hits spaced >60 frames -> lives 0, game_over high exactly 1 cycle, square not drawn; mode=00 -> lives=3, IDLE.
//  5 rst asserted mid-INVULN -> next cycle all outputs 0, lives=3, player at (503,459), IDLE.
//  6 mouse_mode=00, hit=1 held -> lives unchanged, rgb_out = rgb_in delayed 2, game_over never asserted.

Source files
------------

// File: rtl/draw_player.sv
// Player overlay stage: composites a mouse-steered square onto the background
// stream, keeps it inside the arena, and runs the lives / invulnerability /
// game-over state machine. Timing and rgb leave exactly two cycles after entry.
module draw_player #(
    parameter int          TOP_V_LINE    = 317,
    parameter int          BOTTOM_V_LINE = 617,
    parameter int          LEFT_H_LINE   = 361,
    parameter int          RIGHT_H_LINE  = 661,
    parameter int          SIZE          = 16,
    parameter logic [11:0] COLOR         = 12'hf_0_0,
    parameter int          LIVES         = 3,
    parameter int          INVULN_FRAMES = 60
) (
    input  logic        pclk,
    input  logic        rst,

    input  logic [11:0] vcount_in,
    input  logic [11:0] hcount_in,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        vblnk_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,

    input  logic [1:0]  mouse_mode,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        hit,

    output logic [11:0] vcount_out,
    output logic [11:0] hcount_out,
    output logic        vsync_out,
    output logic        hsync_out,
    output logic        vblnk_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out,

    output logic [11:0] player_x,
    output logic [11:0] player_y,
    output logic [2:0]  lives,
    output logic        game_over
);

    // Arena limits for the square's top-left corner and its home position.
    localparam logic [11:0] X_MIN   = 12'(LEFT_H_LINE);
    localparam logic [11:0] X_MAX   = 12'(RIGHT_H_LINE - SIZE);
    localparam logic [11:0] Y_MIN   = 12'(TOP_V_LINE);
    localparam logic [11:0] Y_MAX   = 12'(BOTTOM_V_LINE - SIZE);
    localparam logic [11:0] X_CTR   = 12'((LEFT_H_LINE + RIGHT_H_LINE - SIZE) / 2);
    localparam logic [11:0] Y_CTR   = 12'((TOP_V_LINE + BOTTOM_V_LINE - SIZE) / 2);
    localparam logic [11:0] SIZE_W  = 12'(SIZE);
    localparam logic [2:0]  LIVES_W = 3'(LIVES);
    localparam logic [7:0]  INV_W   = 8'(INVULN_FRAMES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        INVULN = 2'd2,
        DEAD   = 2'd3
    } state_t;

    // Unsigned saturation of a mouse coordinate into [lo, hi].
    function automatic logic [11:0] clamp(input logic [11:0] v,
                                          input logic [11:0] lo,
                                          input logic [11:0] hi);
        if (v < lo)
            clamp = lo;
        else if (v > hi)
            clamp = hi;
        else
            clamp = v;
    endfunction

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [2:0]  lives_q, lives_d;
    logic [7:0]  inv_cnt_q, inv_cnt_d;
    logic [11:0] player_x_q, player_x_d;
    logic [11:0] player_y_q, player_y_d;
    logic        game_over_q, game_over_d;
    logic        vblnk_prev_q;

    logic        game_mode;
    logic        frame_tick;
    logic        visible;

    assign game_mode  = (mouse_mode == 2'b01);
    assign frame_tick = vblnk_in & ~vblnk_prev_q;

    // During invulnerability the square blinks with a 4-frame half period.
    assign visible = (state_q == PLAY) || ((state_q == INVULN) && !inv_cnt_q[2]);

    // Next-state, lives, invulnerability timer and position update.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        inv_cnt_d   = inv_cnt_q;
        player_x_d  = player_x_q;
        player_y_d  = player_y_q;
        game_over_d = 1'b0;

        if (!game_mode) begin
            // Leaving game mode wins over everything, including a hit.
            state_d    = IDLE;
            lives_d    = LIVES_W;
            inv_cnt_d  = 8'd0;
            player_x_d = X_CTR;
            player_y_d = Y_CTR;
        end else begin
            // Position only follows the mouse once per frame while alive.
            if (((state_q == PLAY) || (state_q == INVULN)) && frame_tick) begin
                player_x_d = clamp(xpos, X_MIN, X_MAX);
                player_y_d = clamp(ypos, Y_MIN, Y_MAX);
            end

            case (state_q)
                IDLE: begin
                    state_d    = PLAY;
                    lives_d    = LIVES_W;
                    inv_cnt_d  = 8'd0;
                    player_x_d = X_CTR;
                    player_y_d = Y_CTR;
                end
                PLAY: begin
                    // Leaving PLAY on the first hit cycle makes a held hit count once.
                    if (hit) begin
                        lives_d = lives_q - 3'd1;
                        if (lives_q == 3'd1) begin
                            state_d     = DEAD;
                            game_over_d = 1'b1;
                        end else begin
                            state_d   = INVULN;
                            inv_cnt_d = INV_W;
                        end
                    end
                end
                INVULN: begin
                    if (frame_tick) begin
                        inv_cnt_d = inv_cnt_q - 8'd1;
                        if (inv_cnt_q == 8'd1)
                            state_d = PLAY;
                    end
                end
                DEAD: begin
                    lives_d = 3'd0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control registers, including the vblank edge detector.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= IDLE;
            lives_q      <= LIVES_W;
            inv_cnt_q    <= 8'd0;
            player_x_q   <= X_CTR;
            player_y_q   <= Y_CTR;
            game_over_q  <= 1'b0;
            vblnk_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            inv_cnt_q    <= inv_cnt_d;
            player_x_q   <= player_x_d;
            player_y_q   <= player_y_d;
            game_over_q  <= game_over_d;
            vblnk_prev_q <= vblnk_in;
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
    logic [11:0] vcount_p1_q, vcount_p1_d, vcount_p2_q, vcount_p2_d;
    logic [11:0] hcount_p1_q, hcount_p1_d, hcount_p2_q, hcount_p2_d;
    logic        vsync_p1_q,  vsync_p1_d,  vsync_p2_q,  vsync_p2_d;
    logic        hsync_p1_q,  hsync_p1_d,  hsync_p2_q,  hsync_p2_d;
    logic        vblnk_p1_q,  vblnk_p1_d,  vblnk_p2_q,  vblnk_p2_d;
    logic        hblnk_p1_q,  hblnk_p1_d,  hblnk_p2_q,  hblnk_p2_d;
    logic [11:0] rgb_p1_q,    rgb_p1_d,    rgb_p2_q,    rgb_p2_d;
    logic        draw_p1_q,   draw_p1_d;

    logic inside_h;
    logic inside_v;

    assign inside_h = (hcount_in >= player_x_q) && (hcount_in < player_x_q + SIZE_W);
    assign inside_v = (vcount_in >= player_y_q) && (vcount_in < player_y_q + SIZE_W);

    // Stage 1 captures the stream and decides coverage; stage 2 composites.
    always_comb begin
        // stage 1: register inputs, resolve whether this pixel is the square
        vcount_p1_d = vcount_in;
        hcount_p1_d = hcount_in;
        vsync_p1_d  = vsync_in;
        hsync_p1_d  = hsync_in;
        vblnk_p1_d  = vblnk_in;
        hblnk_p1_d  = hblnk_in;
        rgb_p1_d    = rgb_in;
        draw_p1_d   = inside_h && inside_v && visible && !hblnk_in && !vblnk_in;

        // stage 2: select player colour or pass the background through
        vcount_p2_d = vcount_p1_q;
        hcount_p2_d = hcount_p1_q;
        vsync_p2_d  = vsync_p1_q;
        hsync_p2_d  = hsync_p1_q;
        vblnk_p2_d  = vblnk_p1_q;
        hblnk_p2_d  = hblnk_p1_q;
        rgb_p2_d    = draw_p1_q ? COLOR : rgb_p1_q;
    end

    // Pipeline registers; cleared on reset so outputs start from zero.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vcount_p1_q <= 12'd0;
            hcount_p1_q <= 12'd0;
            vsync_p1_q  <= 1'b0;
            hsync_p1_q  <= 1'b0;
            vblnk_p1_q  <= 1'b0;
            hblnk_p1_q  <= 1'b0;
            rgb_p1_q    <= 12'd0;
            draw_p1_q   <= 1'b0;
            vcount_p2_q <= 12'd0;
            hcount_p2_q <= 12'd0;
            vsync_p2_q  <= 1'b0;
            hsync_p2_q  <= 1'b0;
            vblnk_p2_q  <= 1'b0;
            hblnk_p2_q  <= 1'b0;
            rgb_p2_q    <= 12'd0;
        end else begin
            vcount_p1_q <= vcount_p1_d;
            hcount_p1_q <= hcount_p1_d;
            vsync_p1_q  <= vsync_p1_d;
            hsync_p1_q  <= hsync_p1_d;
            vblnk_p1_q  <= vblnk_p1_d;
            hblnk_p1_q  <= hblnk_p1_d;
            rgb_p1_q    <= rgb_p1_d;
            draw_p1_q   <= draw_p1_d;
            vcount_p2_q <= vcount_p2_d;
            hcount_p2_q <= hcount_p2_d;
            vsync_p2_q  <= vsync_p2_d;
            hsync_p2_q  <= hsync_p2_d;
            vblnk_p2_q  <= vblnk_p2_d;
            hblnk_p2_q  <= hblnk_p2_d;
            rgb_p2_q    <= rgb_p2_d;
        end
    end

    assign vcount_out = vcount_p2_q;
    assign hcount_out = hcount_p2_q;
    assign vsync_out  = vsync_p2_q;
    assign hsync_out  = hsync_p2_q;
    assign vblnk_out  = vblnk_p2_q;
    assign hblnk_out  = hblnk_p2_q;
    assign rgb_out    = rgb_p2_q;

    assign player_x  = player_x_q;
    assign player_y  = player_y_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_draw_player.sv
// Bench for draw_player: constant-expectation tables and hand sequences for
// the corner cases, then random traffic checked against a frame-level model.
module tb_draw_player;

    logic        pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        rst;
    logic [11:0] vcount_in, hcount_in, rgb_in, xpos, ypos;
    logic        vsync_in, hsync_in, vblnk_in, hblnk_in, hit;
    logic [1:0]  mouse_mode;

    logic [11:0] vcount_out, hcount_out, rgb_out, player_x, player_y;
    logic        vsync_out, hsync_out, vblnk_out, hblnk_out, game_over;
    logic [2:0]  lives;

    draw_player dut (
        .pclk(pclk), .rst(rst),
        .vcount_in(vcount_in), .hcount_in(hcount_in),
        .vsync_in(vsync_in), .hsync_in(hsync_in),
        .vblnk_in(vblnk_in), .hblnk_in(hblnk_in), .rgb_in(rgb_in),
        .mouse_mode(mouse_mode), .xpos(xpos), .ypos(ypos), .hit(hit),
        .vcount_out(vcount_out), .hcount_out(hcount_out),
        .vsync_out(vsync_out), .hsync_out(hsync_out),
        .vblnk_out(vblnk_out), .hblnk_out(hblnk_out), .rgb_out(rgb_out),
        .player_x(player_x), .player_y(player_y),
        .lives(lives), .game_over(game_over)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: game in progress flag, lives, frames of immunity left.
    bit m_in_game, m_prev_vb, m_go;
    int m_lives, m_inv, m_px, m_py;

    typedef struct packed {
        logic [11:0] v;
        logic [11:0] h;
        logic        vs, hs, vb, hb;
        logic [11:0] rgb;
    } pix_t;
    pix_t pipe1, pipe2;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit   tick, vis, ins;
        pix_t np;
        tick = vblnk_in && !m_prev_vb;
        vis  = m_in_game && (m_lives > 0) && (m_inv == 0 || (m_inv & 4) == 0);
        ins  = (int'(hcount_in) >= m_px) && (int'(hcount_in) < m_px + 16) &&
               (int'(vcount_in) >= m_py) && (int'(vcount_in) < m_py + 16);
        np.v = vcount_in; np.h = hcount_in;
        np.vs = vsync_in; np.hs = hsync_in; np.vb = vblnk_in; np.hb = hblnk_in;
        np.rgb = (vis && ins && !vblnk_in && !hblnk_in) ? 12'hF00 : rgb_in;
        m_go = 0;
        if (rst) begin
            m_in_game = 0; m_prev_vb = 0; m_lives = 3; m_inv = 0;
            m_px = 503; m_py = 459; pipe1 = '0; pipe2 = '0;
        end else begin
            pipe2 = pipe1;
            pipe1 = np;
            m_prev_vb = vblnk_in;
            if (mouse_mode != 2'b01) begin
                m_in_game = 0; m_lives = 3; m_inv = 0; m_px = 503; m_py = 459;
            end else if (!m_in_game) begin
                m_in_game = 1;
            end else begin
                if (m_lives > 0 && tick) begin
                    m_px = clampi(int'(xpos), 361, 645);
                    m_py = clampi(int'(ypos), 317, 601);
                end
                if (m_lives > 0 && m_inv == 0 && hit) begin
                    m_lives--;
                    if (m_lives == 0) m_go = 1;
                    else m_inv = 60;
                end else if (m_inv > 0 && tick) begin
                    m_inv--;
                end
            end
        end
    endtask

    // One clock: advance the model, clock the DUT, compare everything.
    task automatic step();
        model_step();
        @(posedge pclk);
        #1;
        check("stream", {24'd0, vcount_out, hcount_out, vsync_out, hsync_out,
                         vblnk_out, hblnk_out, rgb_out}, {24'd0, pipe2});
        check("player_x", 64'(player_x), 64'(m_px));
        check("player_y", 64'(player_y), 64'(m_py));
        check("lives", 64'(lives), 64'(m_lives));
        check("game_over", 64'(game_over), 64'(m_go));
    endtask

    task automatic frame();
        vblnk_in = 1'b1; step();
        vblnk_in = 1'b0; step();
    endtask

    typedef struct {
        logic [11:0] x, y, ex, ey;
    } clamp_vec_t;

    typedef struct {
        logic [11:0] h, v, rgb;
        logic        hb, vb;
        logic [11:0] exp_rgb;
    } pix_vec_t;

    clamp_vec_t cvec[7];
    pix_vec_t   pvec[7];

    initial begin
        cvec[0] = '{12'd361,  12'd317, 12'd361, 12'd317};
        cvec[1] = '{12'd645,  12'd601, 12'd645, 12'd601};
        cvec[2] = '{12'd646,  12'd602, 12'd645, 12'd601};
        cvec[3] = '{12'd360,  12'd316, 12'd361, 12'd317};
        cvec[4] = '{12'd4095, 12'd0,   12'd645, 12'd317};
        cvec[5] = '{12'd500,  12'd400, 12'd500, 12'd400};
        cvec[6] = '{12'd503,  12'd459, 12'd503, 12'd459};

        pvec[0] = '{12'd503, 12'd459, 12'h000, 1'b0, 1'b0, 12'hF00};
        pvec[1] = '{12'd519, 12'd459, 12'h0AB, 1'b0, 1'b0, 12'h0AB};
        pvec[2] = '{12'd518, 12'd474, 12'h123, 1'b0, 1'b0, 12'hF00};
        pvec[3] = '{12'd502, 12'd459, 12'h456, 1'b0, 1'b0, 12'h456};
        pvec[4] = '{12'd503, 12'd475, 12'h789, 1'b0, 1'b0, 12'h789};
        pvec[5] = '{12'd510, 12'd465, 12'h777, 1'b1, 1'b0, 12'h777};
        pvec[6] = '{12'd510, 12'd465, 12'h0F0, 1'b0, 1'b1, 12'h0F0};

        rst = 1'b1; mouse_mode = 2'b00; hit = 1'b0;
        vcount_in = '0; hcount_in = '0; rgb_in = '0; xpos = '0; ypos = '0;
        vsync_in = 1'b0; hsync_in = 1'b0; vblnk_in = 1'b0; hblnk_in = 1'b0;
        step(); step();

        // Reset state
        check("rst_lives", 64'(lives), 64'd3);
        check("rst_px", 64'(player_x), 64'd503);
        check("rst_py", 64'(player_y), 64'd459);
        check("rst_rgb", 64'(rgb_out), 64'd0);
        check("rst_go", 64'(game_over), 64'd0);

        // Test 1: first frame tick clamps an out-of-arena mouse position
        rst = 1'b0; mouse_mode = 2'b01; xpos = 12'd100; ypos = 12'd900;
        step();
        frame();
        check("t1_px", 64'(player_x), 64'd361);
        check("t1_py", 64'(player_y), 64'd601);

        // Clamp table: one frame per record
        for (int i = 0; i < 7; i++) begin
            xpos = cvec[i].x; ypos = cvec[i].y;
            frame();
            check("clamp_x", 64'(player_x), 64'(cvec[i].ex));
            check("clamp_y", 64'(player_y), 64'(cvec[i].ey));
        end

        // Pixel table with the player at the centre
        for (int i = 0; i < 7; i++) begin
            hcount_in = pvec[i].h; vcount_in = pvec[i].v; rgb_in = pvec[i].rgb;
            hblnk_in = pvec[i].hb; vblnk_in = pvec[i].vb;
            step(); step();
            check("pixel", 64'(rgb_out), 64'(pvec[i].exp_rgb));
        end
        hblnk_in = 1'b0; vblnk_in = 1'b0; hcount_in = 12'd0; vcount_in = 12'd0;

        // Test 3: held hit counts once; immunity lasts 60 frame ticks
        hit = 1'b1; step(); step(); step(); hit = 1'b0;
        check("t3_hit1", 64'(lives), 64'd2);
        repeat (10) frame();
        hit = 1'b1; step(); hit = 1'b0;
        check("t3_immune10", 64'(lives), 64'd2);
        repeat (49) frame();
        hit = 1'b1; step(); hit = 1'b0;
        check("t3_immune59", 64'(lives), 64'd2);
        frame();
        hit = 1'b1; step(); hit = 1'b0;
        check("t3_play_again", 64'(lives), 64'd1);

        // Test 4: last life lost -> single game_over pulse, square hidden
        repeat (60) frame();
        hcount_in = 12'd503; vcount_in = 12'd459; rgb_in = 12'h5A5;
        hit = 1'b1; step(); hit = 1'b0;
        check("t4_lives0", 64'(lives), 64'd0);
        check("t4_go_pulse", 64'(game_over), 64'd1);
        step();
        check("t4_go_low", 64'(game_over), 64'd0);
        step();
        check("t4_hidden", 64'(rgb_out), 64'h5A5);
        hit = 1'b1; step(); step(); hit = 1'b0;
        check("t4_dead_lives", 64'(lives), 64'd0);
        mouse_mode = 2'b00; step();
        check("t4_reload", 64'(lives), 64'd3);

        // Test 5: reset in the middle of invulnerability
        mouse_mode = 2'b01; step();
        hit = 1'b1; step(); hit = 1'b0;
        repeat (3) frame();
        hcount_in = 12'd100; vcount_in = 12'd200; rgb_in = 12'hFFF;
        vsync_in = 1'b1; hsync_in = 1'b1; vblnk_in = 1'b1; hblnk_in = 1'b1;
        step(); step();
        rst = 1'b1; step();
        check("t5_stream0", {24'd0, vcount_out, hcount_out, vsync_out, hsync_out,
                             vblnk_out, hblnk_out, rgb_out}, 64'd0);
        check("t5_lives", 64'(lives), 64'd3);
        check("t5_px", 64'(player_x), 64'd503);
        check("t5_py", 64'(player_y), 64'd459);
        rst = 1'b0;
        vsync_in = 1'b0; hsync_in = 1'b0; vblnk_in = 1'b0; hblnk_in = 1'b0;

        // Test 6: not playing, hit held -> nothing changes, no overlay
        mouse_mode = 2'b00; hit = 1'b1;
        hcount_in = 12'd503; vcount_in = 12'd459; rgb_in = 12'h3C3;
        repeat (4) step();
        check("t6_lives", 64'(lives), 64'd3);
        check("t6_rgb", 64'(rgb_out), 64'h3C3);
        hit = 1'b0;

        // Random traffic against the model
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 1999) == 0);
            mouse_mode = ($urandom_range(0, 499) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            hit        = ($urandom_range(0, 29) == 0);
            xpos       = 12'($urandom_range(0, 1100));
            ypos       = 12'($urandom_range(0, 1100));
            vblnk_in   = ((i % 8) >= 6);
            hblnk_in   = ($urandom_range(0, 5) == 0);
            vsync_in   = 1'($urandom);
            hsync_in   = 1'($urandom);
            hcount_in  = 12'(m_px - 3 + $urandom_range(0, 22));
            vcount_in  = 12'(m_py - 3 + $urandom_range(0, 22));
            rgb_in     = 12'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
